alu_input_sequencer: RTL and testbench

//  Upstream stage of the 4-bit lab ALU. Loads operand A, operand B and the opcode

---
 rtl/alu_input_sequencer_pkg.sv | 21 ++
 rtl/alu_input_sequencer_debounce.sv | 58 +++++
 rtl/alu_input_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_input_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_input_sequencer_pkg.sv
// Shared types and constants for the ALU input sequencer: FSM states, the ALU
// clear opcode and the bit positions inside the flag nibble.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } state_t;

  localparam logic [3:0] OP_CLEAR = 4'b1111;

  // Flag nibble layout: {carry, overflow, negative, zero}
  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

endpackage

// File: rtl/alu_input_sequencer_debounce.sv
// Button conditioner: two-flop synchroniser, stable-level debounce counter and
// a single-cycle pulse on each debounced 0->1 transition.
module debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise_p
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_prev_q, level_prev_d;

  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    level_prev_d = level_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    // Any return to the accepted level restarts the stability window.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
    end
  end

  assign level  = level_q;
  assign rise_p = level_q & ~level_prev_q;

endmodule

// File: rtl/alu_input_sequencer.sv
// Front end of the lab ALU: steps A, B and the opcode in from the switches on
// each "next" press, captures the ALU result one cycle later and holds it.
module alu_input_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned N               = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  input  logic         btn_next,
  input  logic         btn_clear,
  output logic [N-1:0] a_o,
  output logic [N-1:0] b_o,
  output logic [3:0]   op_o,
  input  logic [N-1:0] alu_y_i,
  input  logic [3:0]   alu_flags_i,
  output logic [N-1:0] result_q,
  output logic [3:0]   flags_q,
  output logic         result_valid,
  output logic [2:0]   state_o
);

  logic next_p, clear_p;
  logic next_level, clear_level;

  debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_next),
    .level   (next_level),
    .rise_p  (next_p)
  );

  debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_clear),
    .level   (clear_level),
    .rise_p  (clear_p)
  );

  state_t       state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [3:0]   op_q, op_d;
  logic [N-1:0] result_d;
  logic [3:0]   flags_d;
  logic         valid_q, valid_d;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    valid_d  = valid_q;
    // Clear overrides a simultaneous next press.
    if (clear_p) begin
      state_d  = S_LOAD_A;
      a_d      = '0;
      b_d      = '0;
      op_d     = OP_CLEAR;
      result_d = '0;
      flags_d  = '0;
      valid_d  = 1'b0;
    end else begin
      case (state_q)
        S_LOAD_A: if (next_p) begin
          a_d     = sw;
          state_d = S_LOAD_B;
        end
        S_LOAD_B: if (next_p) begin
          b_d     = sw;
          state_d = S_LOAD_OP;
        end
        S_LOAD_OP: if (next_p) begin
          op_d    = sw[3:0];
          state_d = S_EXEC;
        end
        // One full cycle for the combinational ALU to settle on the new opcode.
        S_EXEC: begin
          result_d = alu_y_i;
          flags_d  = alu_flags_i;
          valid_d  = 1'b1;
          state_d  = S_SHOW;
        end
        S_SHOW: if (next_p) begin
          valid_d = 1'b0;
          state_d = S_LOAD_A;
        end
        default: state_d = S_LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LOAD_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_CLEAR;
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
    end
  end

  // result_valid has no ready: it stays high from the execute edge until the
  // next press (or clear) starts a new sequence; result_q/flags_q are stable
  // for the whole time it is high.
  assign a_o          = a_q;
  assign b_o          = b_q;
  assign op_o         = op_q;
  assign result_valid = valid_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer with a small 4-bit ALU model on the
// operand outputs and a queue of expected {flags, result} words.
module tb_alu_input_sequencer;

  localparam int unsigned N    = 4;
  localparam int unsigned DB   = 4;
  localparam int          HOLD = DB + 6;

  logic         clk;
  logic         rst;
  logic [N-1:0] sw;
  logic         btn_next;
  logic         btn_clear;
  logic [N-1:0] a_o, b_o;
  logic [3:0]   op_o;
  logic [N-1:0] alu_y;
  logic [3:0]   alu_flags;
  logic [N-1:0] result_q;
  logic [3:0]   flags_q;
  logic         result_valid;
  logic [2:0]   state_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  alu_input_sequencer #(.N(N), .DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .btn_next     (btn_next),
    .btn_clear    (btn_clear),
    .a_o          (a_o),
    .b_o          (b_o),
    .op_o         (op_o),
    .alu_y_i      (alu_y),
    .alu_flags_i  (alu_flags),
    .result_q     (result_q),
    .flags_q      (flags_q),
    .result_valid (result_valid),
    .state_o      (state_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ALU model: 6 = ADD, 7 = SUB; negative reports the true sign of the result.
  always_comb begin
    logic [4:0] wide;
    logic       v;
    wide      = 5'd0;
    v         = 1'b0;
    alu_y     = '0;
    alu_flags = 4'b0000;
    case (op_o)
      4'd6: begin
        wide = {1'b0, a_o} + {1'b0, b_o};
        v    = (a_o[3] == b_o[3]) && (wide[3] != a_o[3]);
      end
      4'd7: begin
        wide = {1'b0, a_o} - {1'b0, b_o};
        v    = (a_o[3] != b_o[3]) && (wide[3] != a_o[3]);
      end
      default: wide = 5'd0;
    endcase
    alu_y     = wide[3:0];
    alu_flags = {wide[4], v, wide[3] ^ v, (wide[3:0] == 4'd0)};
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic press_next(input logic [N-1:0] v);
    sw       = v;
    btn_next = 1'b1;
    tick(HOLD);
    btn_next = 1'b0;
    tick(HOLD);
  endtask

  // Opcode press: pushes the expected word, then times S_EXEC to one cycle.
  task automatic press_op(input logic [3:0] op, input logic [7:0] exp_word);
    int   n;
    logic [7:0] exp;
    sw       = op;
    exp_q.push_back(exp_word);
    btn_next = 1'b1;
    n        = 0;
    while (state_o == 3'd2 && n < 20) begin
      tick(1);
      n++;
    end
    check("op_budget", (n < 20), 1);
    check("exec_state", state_o, 3);
    check("exec_rv_low", result_valid, 0);
    check("op_o", op_o, op);
    tick(1);
    check("show_state", state_o, 4);
    check("show_rv", result_valid, 1);
    check("sb_nonempty", (exp_q.size() != 0), 1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    check("result_word", {flags_q, result_q}, exp);
    tick(HOLD);
    btn_next = 1'b0;
    tick(HOLD);
  endtask

  initial begin
    rst       = 1'b1;
    sw        = '0;
    btn_next  = 1'b0;
    btn_clear = 1'b0;

    // 1. reset
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_a", a_o, 0);
    check("rst_b", b_o, 0);
    check("rst_op", op_o, 4'hF);
    check("rst_rv", result_valid, 0);
    check("rst_state", state_o, 0);

    // 2. short bounce produces no pulse
    sw = 4'd11;
    btn_next = 1'b1; tick(2);
    btn_next = 1'b0; tick(2);
    btn_next = 1'b1; tick(2);
    btn_next = 1'b0; tick(HOLD);
    check("bounce_state", state_o, 0);
    check("bounce_a", a_o, 0);

    // 3. 3 + 5 ADD
    press_next(4'd3);
    check("add_a", a_o, 3);
    check("add_state_b", state_o, 1);
    press_next(4'd5);
    check("add_b", b_o, 5);
    check("add_state_op", state_o, 2);
    press_op(4'd6, {4'b0100, 4'd8});

    // 4. 7 - 7 SUB, then next press leaves S_SHOW
    press_next(4'd0);
    check("show_exit_state", state_o, 0);
    check("show_exit_rv", result_valid, 0);
    press_next(4'd7);
    press_next(4'd7);
    press_op(4'd7, {4'b0001, 4'd0});
    check("sub_zero_flag", flags_q[0], 1);
    press_next(4'd2);
    check("sub_exit_rv", result_valid, 0);
    check("sub_exit_state", state_o, 0);

    // 5. clear and next together: clear wins
    press_next(4'd9);
    check("clr_pre_a", a_o, 9);
    btn_next  = 1'b1;
    btn_clear = 1'b1;
    tick(HOLD);
    btn_next  = 1'b0;
    btn_clear = 1'b0;
    tick(HOLD);
    check("clr_a", a_o, 0);
    check("clr_b", b_o, 0);
    check("clr_op", op_o, 4'hF);
    check("clr_result", {flags_q, result_q}, 8'h00);
    check("clr_rv", result_valid, 0);
    check("clr_state", state_o, 0);

    // 6. reset during S_LOAD_OP with a press being debounced
    press_next(4'd1);
    press_next(4'd2);
    check("rst6_pre_state", state_o, 2);
    sw       = 4'd6;
    btn_next = 1'b1;
    tick(3);
    rst      = 1'b1;
    btn_next = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    check("rst6_a", a_o, 0);
    check("rst6_b", b_o, 0);
    check("rst6_op", op_o, 4'hF);
    check("rst6_state", state_o, 0);
    tick(HOLD);
    check("rst6_no_stale", state_o, 0);
    press_next(4'd4);
    check("rst6_fresh_a", a_o, 4);
    check("rst6_fresh_state", state_o, 1);

    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
